dmem_arbiter: RTL
=================

DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameter DEPTH, default 100, number of 32-bit words in the data memory; word address range 0..DEPTH-1.
REQ-002 clk  input  1  single clock, all state on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 req0/req1  input  1 each  access request from requester 0 (load/store unit) and requester 1 (DMA/debug).
REQ-005 we0/we1  input  1 each  1 = write, 0 = read.
REQ-006 addr0/addr1  input  32 each  word address.
REQ-007 wdata0/wdata1  input  32 each  write data.
REQ-008 gnt0/gnt1  output  1 each  one-cycle pulse: request captured.
REQ-009 rsp_valid0/rsp_valid1  output  1 each  one-cycle pulse: transaction complete.
REQ-010 rsp_err  output  1  qualifies rsp_valid: address out of range.
REQ-011 rsp_rdata  output  32  read data, valid with rsp_valid for a read; 0 otherwise.
REQ-012 d_r_en, d_w_en  output  1 each  memory read/write enables.
REQ-013 d_add, data_in  output  32 each  memory word address and write data.
REQ-014 d_out  input  32  memory read data, registered by memory on the edge that samples d_r_en.

Function
REQ-015 FSM states SHALL be IDLE, ISSUE, RESP; IDLE->ISSUE when any req is sampled high; ISSUE->RESP unconditionally; RESP->IDLE unconditionally.
REQ-016 In IDLE with both reqs high, the requester not granted last SHALL win; with one req high, that requester SHALL win.
REQ-017 On the IDLE->ISSUE edge the winner's we/addr/wdata SHALL be captured into a command register and the winner recorded as last-granted.
REQ-018 In ISSUE, gnt of the winner SHALL be 1 for exactly that cycle; the other gnt SHALL be 0.
REQ-019 In ISSUE, for in-range address, d_w_en = captured we, d_r_en = !captured we, d_add = captured addr, data_in = captured wdata; never both enables high.
REQ-020 Address >= DEPTH SHALL be out of range: no enable asserted in ISSUE, rsp_err = 1 in RESP, rsp_rdata = 0.
REQ-021 In RESP, rsp_valid of the winner SHALL be 1 for one cycle; for an in-range read, rsp_rdata = d_out; for a write, rsp_rdata = 0.
REQ-022 Outside ISSUE, d_r_en, d_w_en, d_add and data_in SHALL be 0; outside RESP, rsp_valid*, rsp_err and rsp_rdata SHALL be 0.
REQ-023 Latency: request sampled at edge k -> gnt in cycle k..k+1, rsp_valid in cycle k+1..k+2; peak throughput one transaction per 3 cycles.
REQ-024 Requesters SHALL hold req/we/addr/wdata stable until gnt; reqs seen in ISSUE or RESP SHALL be ignored until IDLE.
REQ-025 A requester may re-request in the cycle after its rsp_valid; with both reqs held continuously, grants SHALL alternate 0,1,0,1...

Reset
REQ-026 rst high SHALL force state IDLE, last-granted = 1 (requester 0 wins first tie), command register = 0, and all outputs = 0, asynchronously.
REQ-027 rst asserted in ISSUE or RESP SHALL abort the transaction: no rsp_valid for it, no further memory enable.
REQ-028 First request SHALL be sampled on the first rising clk edge after rst deasserts.

Structure
REQ-029 Shared package dmem_arb_pkg SHALL hold the state enum (IDLE, ISSUE, RESP), DEPTH default, and requester index constants REQ_LSU = 0, REQ_DMA = 1.
REQ-030 One sub-module rr_pick2 SHALL implement the 2-way round-robin selection (inputs req0, req1, last; output winner, any).

Verification
REQ-031 Reset then req0 write addr 5 data 0xDEADBEEF -> gnt0 next cycle, d_w_en = 1, d_add = 5, rsp_valid0 following cycle, rsp_err = 0.
REQ-032 req0 read addr 5 after REQ-031 -> d_r_en one cycle, rsp_valid0 with rsp_rdata = 0xDEADBEEF.
REQ-033 req0 and req1 both held high, reads addr 1 and 2 -> grants 0,1,0,1; gnt never both high; enables never both high.
REQ-034 req1 read addr 100 (DEPTH = 100) -> no enable asserted, rsp_valid1 with rsp_err = 1, rsp_rdata = 0.
REQ-035 rst pulsed during ISSUE of a write to addr 7 -> all outputs 0 immediately, no rsp_valid, next read of addr 7 returns the prior value.
REQ-036 req1 write addr 3 data 0x12345678 while req0 idle, then req0 read addr 3 -> rsp_rdata = 0x12345678 on rsp_valid0.

Source files
------------

// File: rtl/dmem_arb_pkg.sv
// Shared definitions for the two-requester data-memory arbiter:
// FSM state encoding, default memory depth and requester indices.
package dmem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_e;

  localparam int DEPTH_DEFAULT = 100;

  localparam logic REQ_LSU = 1'b0;
  localparam logic REQ_DMA = 1'b1;

endpackage

// File: rtl/dmem_arbiter_rr_pick2.sv
// Two-way round-robin pick: on a tie the requester not granted last wins;
// a lone request always wins.
module rr_pick2
  import dmem_arb_pkg::*;
(
  input  logic req0,
  input  logic req1,
  input  logic last,
  output logic winner,
  output logic any
);

  always_comb begin
    any    = req0 | req1;
    winner = REQ_LSU;
    if (req0 && req1) begin
      winner = ~last;
    end else if (req1) begin
      winner = REQ_DMA;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Arbitrates two requesters onto a single-port data memory. Each transaction
// runs IDLE -> ISSUE (grant + memory access) -> RESP (response pulse).
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0,
  input  logic        req1,
  input  logic        we0,
  input  logic        we1,
  input  logic [31:0] addr0,
  input  logic [31:0] addr1,
  input  logic [31:0] wdata0,
  input  logic [31:0] wdata1,
  output logic        gnt0,
  output logic        gnt1,
  output logic        rsp_valid0,
  output logic        rsp_valid1,
  output logic        rsp_err,
  output logic [31:0] rsp_rdata,
  output logic        d_r_en,
  output logic        d_w_en,
  output logic [31:0] d_add,
  output logic [31:0] data_in,
  input  logic [31:0] d_out
);

  state_e      state_q, state_d;
  logic        last_q, last_d;
  logic        cmd_who_q, cmd_who_d;
  logic        cmd_we_q, cmd_we_d;
  logic        cmd_err_q, cmd_err_d;
  logic [31:0] cmd_addr_q, cmd_addr_d;
  logic [31:0] cmd_wdata_q, cmd_wdata_d;
  logic        gnt0_q, gnt0_d, gnt1_q, gnt1_d;
  logic        d_r_en_q, d_r_en_d, d_w_en_q, d_w_en_d;
  logic [31:0] d_add_q, d_add_d, data_in_q, data_in_d;
  logic        rsp_valid0_q, rsp_valid0_d, rsp_valid1_q, rsp_valid1_d;
  logic        rsp_err_q, rsp_err_d;
  logic        rsp_rd_q, rsp_rd_d;

  logic        win;
  logic        any_req;
  logic        win_we;
  logic [31:0] win_addr;
  logic [31:0] win_wdata;
  logic        win_err;

  rr_pick2 u_pick (
    .req0   (req0),
    .req1   (req1),
    .last   (last_q),
    .winner (win),
    .any    (any_req)
  );

  always_comb begin
    win_we    = (win == REQ_DMA) ? we1    : we0;
    win_addr  = (win == REQ_DMA) ? addr1  : addr0;
    win_wdata = (win == REQ_DMA) ? wdata1 : wdata0;
    win_err   = (win_addr >= 32'(DEPTH));
  end

  // Every output is a one-state pulse, so all output _d default to 0.
  always_comb begin
    state_d      = state_q;
    last_d       = last_q;
    cmd_who_d    = cmd_who_q;
    cmd_we_d     = cmd_we_q;
    cmd_err_d    = cmd_err_q;
    cmd_addr_d   = cmd_addr_q;
    cmd_wdata_d  = cmd_wdata_q;
    gnt0_d       = 1'b0;
    gnt1_d       = 1'b0;
    d_r_en_d     = 1'b0;
    d_w_en_d     = 1'b0;
    d_add_d      = '0;
    data_in_d    = '0;
    rsp_valid0_d = 1'b0;
    rsp_valid1_d = 1'b0;
    rsp_err_d    = 1'b0;
    rsp_rd_d     = 1'b0;
    case (state_q)
      IDLE: begin
        if (any_req) begin
          state_d     = ISSUE;
          last_d      = win;
          cmd_who_d   = win;
          cmd_we_d    = win_we;
          cmd_err_d   = win_err;
          cmd_addr_d  = win_addr;
          cmd_wdata_d = win_wdata;
          gnt0_d      = (win == REQ_LSU);
          gnt1_d      = (win == REQ_DMA);
          if (!win_err) begin
            d_w_en_d  = win_we;
            d_r_en_d  = !win_we;
            d_add_d   = win_addr;
            data_in_d = win_wdata;
          end
        end
      end
      ISSUE: begin
        state_d      = RESP;
        rsp_valid0_d = (cmd_who_q == REQ_LSU);
        rsp_valid1_d = (cmd_who_q == REQ_DMA);
        rsp_err_d    = cmd_err_q;
        rsp_rd_d     = !cmd_we_q && !cmd_err_q;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      last_q       <= REQ_DMA;
      cmd_who_q    <= 1'b0;
      cmd_we_q     <= 1'b0;
      cmd_err_q    <= 1'b0;
      cmd_addr_q   <= '0;
      cmd_wdata_q  <= '0;
      gnt0_q       <= 1'b0;
      gnt1_q       <= 1'b0;
      d_r_en_q     <= 1'b0;
      d_w_en_q     <= 1'b0;
      d_add_q      <= '0;
      data_in_q    <= '0;
      rsp_valid0_q <= 1'b0;
      rsp_valid1_q <= 1'b0;
      rsp_err_q    <= 1'b0;
      rsp_rd_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_q       <= last_d;
      cmd_who_q    <= cmd_who_d;
      cmd_we_q     <= cmd_we_d;
      cmd_err_q    <= cmd_err_d;
      cmd_addr_q   <= cmd_addr_d;
      cmd_wdata_q  <= cmd_wdata_d;
      gnt0_q       <= gnt0_d;
      gnt1_q       <= gnt1_d;
      d_r_en_q     <= d_r_en_d;
      d_w_en_q     <= d_w_en_d;
      d_add_q      <= d_add_d;
      data_in_q    <= data_in_d;
      rsp_valid0_q <= rsp_valid0_d;
      rsp_valid1_q <= rsp_valid1_d;
      rsp_err_q    <= rsp_err_d;
      rsp_rd_q     <= rsp_rd_d;
    end
  end

  assign gnt0       = gnt0_q;
  assign gnt1       = gnt1_q;
  assign d_r_en     = d_r_en_q;
  assign d_w_en     = d_w_en_q;
  assign d_add      = d_add_q;
  assign data_in    = data_in_q;
  assign rsp_valid0 = rsp_valid0_q;
  assign rsp_valid1 = rsp_valid1_q;
  assign rsp_err    = rsp_err_q;
  // Memory registers its read data on the ISSUE->RESP edge, so pass it through.
  assign rsp_rdata  = rsp_rd_q ? d_out : 32'd0;

endmodule
